// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the pipelined control/hazard unit.
//   - op/funct field codes, ALU control and forward-select encodings
//   - ctrl_t: control bundle carried down the pipeline, CTRL_BUBBLE constant
//   - fwd_sel(): E-stage forwarding select for one source register
package cu_pkg;

   localparam int unsigned CU_REG_AW = 5;
   localparam int unsigned CU_ALU_CW = 3;
   localparam int unsigned CU_OP_W   = 6;

   localparam logic [CU_OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [CU_OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [CU_OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [CU_OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [CU_OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [CU_OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [CU_OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [CU_OP_W-1:0] FN_SUB = 6'b100010;
   localparam logic [CU_OP_W-1:0] FN_AND = 6'b100100;
   localparam logic [CU_OP_W-1:0] FN_OR  = 6'b100101;
   localparam logic [CU_OP_W-1:0] FN_SLT = 6'b101010;

   typedef enum logic [CU_ALU_CW-1:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctl_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic     reg_write;
      logic     reg_dst;
      logic     alu_src;
      logic     branch;
      logic     mem_write;
      logic     mem_to_reg;
      alu_ctl_e alu_control;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{
      reg_write:   1'b0,
      reg_dst:     1'b0,
      alu_src:     1'b0,
      branch:      1'b0,
      mem_write:   1'b0,
      mem_to_reg:  1'b0,
      alu_control: ALU_ADD
   };

   // M has priority over W; $0 is never forwarded.
   function automatic fwd_sel_e fwd_sel(
      input logic [CU_REG_AW-1:0] src,
      input logic                 rw_m,
      input logic [CU_REG_AW-1:0] wr_m,
      input logic                 rw_w,
      input logic [CU_REG_AW-1:0] wr_w
   );
      if (rw_m && (wr_m != '0) && (wr_m == src)) return FWD_M;
      if (rw_w && (wr_w != '0) && (wr_w == src)) return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/cu_if.sv
// cu_if: D-stage instruction fields in, pipeline control out.
//   master : instruction/flag source (drives op_d..zero_e, observes controls)
//   slave  : the control unit (cu_pipe)
// With CU_JUMP_EN defined the extra jump_d output is present.
interface cu_if
   import cu_pkg::*;
#(
   parameter int unsigned REG_AW = CU_REG_AW,
   parameter int unsigned ALU_CW = CU_ALU_CW,
   parameter int unsigned OP_W   = CU_OP_W
) ();

   logic [OP_W-1:0]   op_d;
   logic [OP_W-1:0]   funct_d;
   logic [REG_AW-1:0] rs_d;
   logic [REG_AW-1:0] rt_d;
   logic [REG_AW-1:0] rd_d;
   logic              zero_e;

   logic              illegal_d;
   logic              stall_f;
   logic              stall_d;
   logic              flush_d;
   logic              pc_src_e;
   logic              reg_dst_e;
   logic              alu_src_e;
   logic [ALU_CW-1:0] alu_control_e;
   logic [1:0]        forward_a_e;
   logic [1:0]        forward_b_e;
   logic              mem_write_m;
   logic              reg_write_w;
   logic              mem_to_reg_w;
   logic [REG_AW-1:0] write_reg_m;
   logic [REG_AW-1:0] write_reg_w;
`ifdef CU_JUMP_EN
   logic              jump_d;
`endif

   modport master (
      output op_d, funct_d, rs_d, rt_d, rd_d, zero_e,
      input  illegal_d, stall_f, stall_d, flush_d, pc_src_e,
      input  reg_dst_e, alu_src_e, alu_control_e, forward_a_e, forward_b_e,
      input  mem_write_m, reg_write_w, mem_to_reg_w, write_reg_m, write_reg_w
`ifdef CU_JUMP_EN
      , input jump_d
`endif
   );

   modport slave (
      input  op_d, funct_d, rs_d, rt_d, rd_d, zero_e,
      output illegal_d, stall_f, stall_d, flush_d, pc_src_e,
      output reg_dst_e, alu_src_e, alu_control_e, forward_a_e, forward_b_e,
      output mem_write_m, reg_write_w, mem_to_reg_w, write_reg_m, write_reg_w
`ifdef CU_JUMP_EN
      , output jump_d
`endif
   );

endinterface

// File: rtl/cu_decode.sv
// cu_decode: combinational D-stage decoder, op/funct -> ctrl_t.
//   op_i, funct_i : instruction fields
//   ctrl_o        : control bundle (CTRL_BUBBLE for anything not decodable)
//   illegal_o     : op/funct not decodable
//   jump_o        : j decoded (only with CU_JUMP_EN defined)
module cu_decode
   import cu_pkg::*;
(
   input  logic [CU_OP_W-1:0] op_i,
   input  logic [CU_OP_W-1:0] funct_i,
   output ctrl_t              ctrl_o,
`ifdef CU_JUMP_EN
   output logic               jump_o,
`endif
   output logic               illegal_o
);

   always_comb begin
      ctrl_o    = CTRL_BUBBLE;
      illegal_o = 1'b0;
`ifdef CU_JUMP_EN
      jump_o    = 1'b0;
`endif
      case (op_i)
         OP_RTYPE: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
            case (funct_i)
               FN_ADD:  ctrl_o.alu_control = ALU_ADD;
               FN_SUB:  ctrl_o.alu_control = ALU_SUB;
               FN_AND:  ctrl_o.alu_control = ALU_AND;
               FN_OR:   ctrl_o.alu_control = ALU_OR;
               FN_SLT:  ctrl_o.alu_control = ALU_SLT;
               default: begin
                  ctrl_o    = CTRL_BUBBLE;
                  illegal_o = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl_o.branch      = 1'b1;
            ctrl_o.alu_control = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
         end
`ifdef CU_JUMP_EN
         OP_J: jump_o = 1'b1;
`endif
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/cu_pipe.sv
// cu_pipe: pipelined control and hazard unit for the 5-stage MIPS core.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset, clears every stage to a bubble
//   bus     : cu_if.slave -- D-stage op/funct/rs/rt/rd and zero_e in;
//             illegal_d, stall_f/d, flush_d, pc_src_e, E-stage muxes,
//             forwarding selects, M/W controls and write_reg_m/w out
// Optional feature: CU_JUMP_EN adds j decode, jump_d output, flush on jump.
module cu_pipe
   import cu_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   cu_if.slave  bus
);

   ctrl_t                dec_ctrl;
   logic                 dec_illegal;
`ifdef CU_JUMP_EN
   logic                 dec_jump;
`endif

   // D/E register
   ctrl_t                ctrl_e_q, ctrl_e_d;
   logic [CU_REG_AW-1:0] rs_e_q, rs_e_d;
   logic [CU_REG_AW-1:0] rt_e_q, rt_e_d;
   logic [CU_REG_AW-1:0] rd_e_q, rd_e_d;
   // E/M register
   logic                 reg_write_m_q, mem_write_m_q, mem_to_reg_m_q;
   logic [CU_REG_AW-1:0] write_reg_m_q;
   // M/W register
   logic                 reg_write_w_q, mem_to_reg_w_q;
   logic [CU_REG_AW-1:0] write_reg_w_q;

   logic                 lwstall, pc_src, flush_e;
   logic [CU_REG_AW-1:0] write_reg_e;

   cu_decode u_decode (
      .op_i      (bus.op_d),
      .funct_i   (bus.funct_d),
      .ctrl_o    (dec_ctrl),
`ifdef CU_JUMP_EN
      .jump_o    (dec_jump),
`endif
      .illegal_o (dec_illegal)
   );

   assign lwstall     = ctrl_e_q.mem_to_reg & ((rt_e_q == bus.rs_d) | (rt_e_q == bus.rt_d));
   assign pc_src      = ctrl_e_q.branch & bus.zero_e;
   assign flush_e     = lwstall | pc_src;
   assign write_reg_e = ctrl_e_q.reg_dst ? rd_e_q : rt_e_q;

   // A flushed slot also zeroes its register fields so a bubble in E
   // never matches a forwarding source.
   always_comb begin
      ctrl_e_d = dec_ctrl;
      rs_e_d   = bus.rs_d;
      rt_e_d   = bus.rt_d;
      rd_e_d   = bus.rd_d;
      if (flush_e) begin
         ctrl_e_d = CTRL_BUBBLE;
         rs_e_d   = '0;
         rt_e_d   = '0;
         rd_e_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_e_q       <= CTRL_BUBBLE;
         rs_e_q         <= '0;
         rt_e_q         <= '0;
         rd_e_q         <= '0;
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         mem_to_reg_m_q <= 1'b0;
         write_reg_m_q  <= '0;
         reg_write_w_q  <= 1'b0;
         mem_to_reg_w_q <= 1'b0;
         write_reg_w_q  <= '0;
      end else begin
         ctrl_e_q       <= ctrl_e_d;
         rs_e_q         <= rs_e_d;
         rt_e_q         <= rt_e_d;
         rd_e_q         <= rd_e_d;
         reg_write_m_q  <= ctrl_e_q.reg_write;
         mem_write_m_q  <= ctrl_e_q.mem_write;
         mem_to_reg_m_q <= ctrl_e_q.mem_to_reg;
         write_reg_m_q  <= write_reg_e;
         reg_write_w_q  <= reg_write_m_q;
         mem_to_reg_w_q <= mem_to_reg_m_q;
         write_reg_w_q  <= write_reg_m_q;
      end
   end

   assign bus.illegal_d     = dec_illegal;
   assign bus.stall_f       = lwstall;
   assign bus.stall_d       = lwstall;
`ifdef CU_JUMP_EN
   assign bus.jump_d        = dec_jump;
   assign bus.flush_d       = pc_src | dec_jump;
`else
   assign bus.flush_d       = pc_src;
`endif
   assign bus.pc_src_e      = pc_src;
   assign bus.reg_dst_e     = ctrl_e_q.reg_dst;
   assign bus.alu_src_e     = ctrl_e_q.alu_src;
   assign bus.alu_control_e = ctrl_e_q.alu_control;
   assign bus.forward_a_e   = fwd_sel(rs_e_q, reg_write_m_q, write_reg_m_q,
                                      reg_write_w_q, write_reg_w_q);
   assign bus.forward_b_e   = fwd_sel(rt_e_q, reg_write_m_q, write_reg_m_q,
                                      reg_write_w_q, write_reg_w_q);
   assign bus.mem_write_m   = mem_write_m_q;
   assign bus.reg_write_w   = reg_write_w_q;
   assign bus.mem_to_reg_w  = mem_to_reg_w_q;
   assign bus.write_reg_m   = write_reg_m_q;
   assign bus.write_reg_w   = write_reg_w_q;

endmodule
